udp_tx_pkt_arbiter: RTL and testbench

UDP_TX_PKT_ARBITER -- requirements
Module: udp_tx_pkt_arbiter

---
 rtl/udp_tx_pkt_arbiter_pkg.sv | 27 ++
 rtl/udp_tx_pkt_arbiter_rr_arb2.sv | 22 ++
 rtl/udp_tx_pkt_arbiter.sv | 179 +++++++++++++++++
 tb/tb_udp_tx_pkt_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_tx_pkt_arbiter_pkg.sv
// Shared types and constants for the two-requester UDP TX packet arbiter.
package udp_tx_pkt_arbiter_pkg;

  // AXI-Stream widths used on every port of the arbiter.
  localparam int AXIS_DATA_WIDTH = 512;
  localparam int AXIS_KEEP_WIDTH = 64;
  localparam int AXIS_USER_WIDTH = 1;

  // Arbiter FSM: wait for a request, forward one whole packet, then idle out the gap.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // Requester index: 0 = XDMA H2C stream, 1 = perf-monitor generator.
  typedef logic req_idx_t;

  localparam req_idx_t REQ_S0 = 1'b0;
  localparam req_idx_t REQ_S1 = 1'b1;

  // Collapse a one-hot two-bit grant into a requester index.
  function automatic req_idx_t onehot_to_idx(input logic [1:0] onehot);
    return req_idx_t'(onehot[1]);
  endfunction

endpackage

// File: rtl/udp_tx_pkt_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// requester that did not own the previous packet.
module rr_arb2
  import udp_tx_pkt_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last_grant,
  output logic [1:0] grant
);

  // Purely combinational pick; the caller registers the result.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == REQ_S1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/udp_tx_pkt_arbiter.sv
// Packet-granular arbiter merging the XDMA H2C stream (s0) and the
// perf-monitor stream (s1) onto the shared UDP/CMAC TX stream (m).
//
// Handshake: every AXIS port transfers a beat on a rising CLK edge where
// tvalid and tready are both high; a source holds tvalid and its payload
// stable until that happens. Only the owning slave sees m_axis_tready, so
// the non-owner is stalled with tready=0 and is never partially consumed.
module udp_tx_pkt_arbiter
  import udp_tx_pkt_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int KEEP_WIDTH = AXIS_KEEP_WIDTH,
  parameter int USER_WIDTH = AXIS_USER_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST_N,

  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic                  s0_axis_tlast,
  input  logic [USER_WIDTH-1:0] s0_axis_tuser,

  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic                  s1_axis_tlast,
  input  logic [USER_WIDTH-1:0] s1_axis_tuser,

  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,

  input  logic [31:0]           cfg_pkt_interval,
  output logic [1:0]            grant_out,
  output logic [31:0]           pkt_count0_out,
  output logic [31:0]           pkt_count1_out,
  output logic [31:0]           beat_count_out,
  output arb_state_e            state_dbg
);

  arb_state_e  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  req_idx_t    last_grant_q, last_grant_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;
  logic [31:0] pkt_count0_q, pkt_count1_q, beat_count_q;

  logic [1:0]  rr_pick;
  req_idx_t    owner;
  logic        in_xfer;
  logic        m_hs;
  logic        m_last_hs;

  assign owner   = onehot_to_idx(grant_q);
  assign in_xfer = (state_q == ST_XFER);

  rr_arb2 u_rr_arb2 (
    .req        ({s1_axis_tvalid, s0_axis_tvalid}),
    .last_grant (last_grant_q),
    .grant      (rr_pick)
  );

  // Steer the owner's stream to the master port; everything is quiet outside XFER.
  always_comb begin
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = '0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    if (in_xfer) begin
      if (owner == REQ_S1) begin
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tlast   = s1_axis_tlast;
        m_axis_tuser   = s1_axis_tuser;
        s1_axis_tready = m_axis_tready;
      end else begin
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tlast   = s0_axis_tlast;
        m_axis_tuser   = s0_axis_tuser;
        s0_axis_tready = m_axis_tready;
      end
    end
  end

  assign m_hs      = m_axis_tvalid & m_axis_tready;
  assign m_last_hs = m_hs & m_axis_tlast;

  // Next-state logic: grants only move at packet boundaries, the gap length is latched at tlast.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    gap_cnt_d    = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_pick != 2'b00) begin
          state_d = ST_XFER;
          grant_d = rr_pick;
        end
      end
      ST_XFER: begin
        if (m_last_hs) begin
          grant_d      = 2'b00;
          last_grant_d = owner;
          if (cfg_pkt_interval != 32'd0) begin
            state_d   = ST_GAP;
            gap_cnt_d = cfg_pkt_interval;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - 32'd1;
        if (gap_cnt_q <= 32'd1) begin
          state_d   = ST_IDLE;
          gap_cnt_d = 32'd0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        grant_d   = 2'b00;
        gap_cnt_d = 32'd0;
      end
    endcase
  end

  // FSM, grant and gap registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= REQ_S1;
      gap_cnt_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  // Traffic counters; all wrap naturally at 2^32.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pkt_count0_q <= 32'd0;
      pkt_count1_q <= 32'd0;
      beat_count_q <= 32'd0;
    end else begin
      if (m_hs) begin
        beat_count_q <= beat_count_q + 32'd1;
      end
      if (m_last_hs && (owner == REQ_S0)) begin
        pkt_count0_q <= pkt_count0_q + 32'd1;
      end
      if (m_last_hs && (owner == REQ_S1)) begin
        pkt_count1_q <= pkt_count1_q + 32'd1;
      end
    end
  end

  assign grant_out      = grant_q;
  assign pkt_count0_out = pkt_count0_q;
  assign pkt_count1_out = pkt_count1_q;
  assign beat_count_out = beat_count_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_udp_tx_pkt_arbiter.sv
// Directed bench for udp_tx_pkt_arbiter: two scripted packet sources, an
// expected-beat queue on the master side and hand-computed counter/timing checks.
module tb_udp_tx_pkt_arbiter;
  import udp_tx_pkt_arbiter_pkg::*;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 1;

  // ---------------- clock / reset ----------------
  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic          s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
  logic [DW-1:0] s0_axis_tdata;
  logic [KW-1:0] s0_axis_tkeep;
  logic [UW-1:0] s0_axis_tuser;
  logic          s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
  logic [DW-1:0] s1_axis_tdata;
  logic [KW-1:0] s1_axis_tkeep;
  logic [UW-1:0] s1_axis_tuser;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic [31:0]   cfg_pkt_interval;
  logic [1:0]    grant_out;
  logic [31:0]   pkt_count0_out, pkt_count1_out, beat_count_out;
  arb_state_e    state_dbg;

  udp_tx_pkt_arbiter dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .s0_axis_tvalid   (s0_axis_tvalid),
    .s0_axis_tready   (s0_axis_tready),
    .s0_axis_tdata    (s0_axis_tdata),
    .s0_axis_tkeep    (s0_axis_tkeep),
    .s0_axis_tlast    (s0_axis_tlast),
    .s0_axis_tuser    (s0_axis_tuser),
    .s1_axis_tvalid   (s1_axis_tvalid),
    .s1_axis_tready   (s1_axis_tready),
    .s1_axis_tdata    (s1_axis_tdata),
    .s1_axis_tkeep    (s1_axis_tkeep),
    .s1_axis_tlast    (s1_axis_tlast),
    .s1_axis_tuser    (s1_axis_tuser),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .cfg_pkt_interval (cfg_pkt_interval),
    .grant_out        (grant_out),
    .pkt_count0_out   (pkt_count0_out),
    .pkt_count1_out   (pkt_count1_out),
    .beat_count_out   (beat_count_out),
    .state_dbg        (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int            vectors     = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q[$];
  int            log_cyc[$];
  int            log_gap[$];

  // ---------------- source models ----------------
  int          s_len[2];
  int          s_npkt[2];
  int          s_pkt[2];
  int          s_beat[2];
  int          s_start[2];
  bit          hs[2];
  int          test_id;
  int          cyc;
  int          gap_seen;
  bit          tready_toggle;
  logic        tr;
  int          cfg_change_cyc;
  logic [31:0] cfg_change_val;

  localparam logic [KW-1:0] KEEP_S0 = {KW{1'b1}};
  localparam logic [KW-1:0] KEEP_S1 = {{(KW/2){1'b0}}, {(KW/2){1'b1}}};

  // Payload tag: [31:24] test, [17:16] requester+1, [15:8] packet, [7:0] beat.
  function automatic logic [DW-1:0] src_data(input int r, input int p, input int b);
    logic [31:0] w;
    w = (32'(test_id) << 24) | (32'(r + 1) << 16) | (32'(p) << 8) | 32'(b);
    return DW'(w);
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int r, input int p, input int len);
    for (int b = 0; b < len; b++) exp_q.push_back(src_data(r, p, b));
  endtask

  task automatic clear_src();
    for (int r = 0; r < 2; r++) begin
      s_len[r]   = 1;
      s_npkt[r]  = 0;
      s_pkt[r]   = 0;
      s_beat[r]  = 0;
      s_start[r] = 0;
      hs[r]      = 1'b0;
    end
    cyc            = 0;
    gap_seen       = 0;
    cfg_change_cyc = -1;
    cfg_change_val = 32'd0;
    tready_toggle  = 1'b0;
    tr             = 1'b0;
    exp_q.delete();
    log_cyc.delete();
    log_gap.delete();
  endtask

  task automatic idle_inputs();
    s0_axis_tvalid = 1'b0;
    s0_axis_tdata  = '0;
    s0_axis_tkeep  = '0;
    s0_axis_tlast  = 1'b0;
    s0_axis_tuser  = '0;
    s1_axis_tvalid = 1'b0;
    s1_axis_tdata  = '0;
    s1_axis_tkeep  = '0;
    s1_axis_tlast  = 1'b0;
    s1_axis_tuser  = '0;
    m_axis_tready  = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    idle_inputs();
    clear_src();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // One cycle: advance sources on last edge's handshakes, drive, then score the master port mid-cycle.
  task automatic step();
    logic [DW-1:0] e;
    logic [DW-1:0] e_tmp;
    logic [1:0]    own;
    @(negedge CLK);
    for (int r = 0; r < 2; r++) begin
      if (hs[r]) begin
        s_beat[r]++;
        if (s_beat[r] == s_len[r]) begin
          s_beat[r] = 0;
          s_pkt[r]++;
        end
        hs[r] = 1'b0;
      end
    end
    if (cyc == cfg_change_cyc) cfg_pkt_interval = cfg_change_val;
    s0_axis_tvalid = (s_pkt[0] < s_npkt[0]) && (cyc >= s_start[0]);
    s0_axis_tdata  = src_data(0, s_pkt[0], s_beat[0]);
    s0_axis_tkeep  = KEEP_S0;
    s0_axis_tlast  = (s_beat[0] == s_len[0] - 1);
    s0_axis_tuser  = UW'(0);
    s1_axis_tvalid = (s_pkt[1] < s_npkt[1]) && (cyc >= s_start[1]);
    s1_axis_tdata  = src_data(1, s_pkt[1], s_beat[1]);
    s1_axis_tkeep  = KEEP_S1;
    s1_axis_tlast  = (s_beat[1] == s_len[1] - 1);
    s1_axis_tuser  = UW'(1);
    if (tready_toggle) tr = ~tr;
    else tr = 1'b1;
    m_axis_tready = tr;
    #1;
    hs[0] = s0_axis_tvalid && s0_axis_tready;
    hs[1] = s1_axis_tvalid && s1_axis_tready;
    if (state_dbg == ST_GAP) gap_seen++;
    if (m_axis_tvalid && grant_out == 2'b10) check("s0_tready_blocked", DW'(s0_axis_tready), DW'(0));
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_beat: observed %0h expected no beat", m_axis_tdata);
      end else begin
        e     = exp_q.pop_front();
        e_tmp = e;
        own   = e_tmp[17:16];
        check("m_tdata", m_axis_tdata, e);
        check("m_tkeep", DW'(m_axis_tkeep), DW'((own == 2'd1) ? KEEP_S0 : KEEP_S1));
        check("m_tuser", DW'(m_axis_tuser), DW'((own == 2'd1) ? 1'b0 : 1'b1));
        check("grant_out", DW'(grant_out), DW'((own == 2'd1) ? 2'b01 : 2'b10));
        log_cyc.push_back(cyc);
        log_gap.push_back(gap_seen);
      end
    end
    cyc++;
  endtask

  // Step until every expected beat has appeared (bounded), then one settle cycle.
  task automatic run(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_timeout: observed %0d beats pending expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle_inputs();
    cfg_pkt_interval = 32'd0;
    clear_src();
    test_id = 0;

    // Reset values.
    @(negedge CLK);
    #1;
    check("rst_state", DW'(state_dbg), DW'(ST_IDLE));
    check("rst_grant", DW'(grant_out), DW'(0));
    check("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    check("rst_s0_tready", DW'(s0_axis_tready), DW'(0));
    check("rst_s1_tready", DW'(s1_axis_tready), DW'(0));
    check("rst_beat_count", DW'(beat_count_out), DW'(0));
    check("rst_pkt_count0", DW'(pkt_count0_out), DW'(0));
    check("rst_pkt_count1", DW'(pkt_count1_out), DW'(0));

    // Single 4-beat packet from s0: first beat one cycle after valid, then back to back.
    do_reset();
    test_id = 1;
    s_len[0] = 4; s_npkt[0] = 1;
    push_pkt(0, 0, 4);
    run("t1", 40);
    check("t1_first_beat_cyc", DW'(log_cyc[0]), DW'(1));
    check("t1_last_beat_cyc", DW'(log_cyc[3]), DW'(4));
    check("t1_pkt_count0", DW'(pkt_count0_out), DW'(1));
    check("t1_pkt_count1", DW'(pkt_count1_out), DW'(0));
    check("t1_beat_count", DW'(beat_count_out), DW'(4));
    check("t1_idle_tvalid", DW'(m_axis_tvalid), DW'(0));
    check("t1_idle_grant", DW'(grant_out), DW'(0));

    // Both sources saturated with 2-beat packets: strict alternation starting at s0.
    do_reset();
    test_id = 2;
    s_len[0] = 2; s_npkt[0] = 2;
    s_len[1] = 2; s_npkt[1] = 2;
    push_pkt(0, 0, 2); push_pkt(1, 0, 2);
    push_pkt(0, 1, 2); push_pkt(1, 1, 2);
    run("t2", 60);
    check("t2_second_pkt_cyc", DW'(log_cyc[2]), DW'(4));
    check("t2_last_beat_cyc", DW'(log_cyc[7]), DW'(11));
    check("t2_pkt_count0", DW'(pkt_count0_out), DW'(2));
    check("t2_pkt_count1", DW'(pkt_count1_out), DW'(2));
    check("t2_beat_count", DW'(beat_count_out), DW'(8));
    check("t2_no_gap", DW'(gap_seen), DW'(0));

    // Interval 5 between two 1-beat packets; interval edited mid-gap to 1.
    do_reset();
    test_id = 3;
    cfg_pkt_interval = 32'd5;
    cfg_change_cyc = 3;
    cfg_change_val = 32'd1;
    s_len[0] = 1; s_npkt[0] = 2;
    push_pkt(0, 0, 1); push_pkt(0, 1, 1);
    run("t3", 60);
    check("t3_tlast_spacing", DW'(log_cyc[1] - log_cyc[0]), DW'(7));
    check("t3_gap_cycles", DW'(log_gap[1] - log_gap[0]), DW'(5));
    check("t3_pkt_count0", DW'(pkt_count0_out), DW'(2));
    check("t3_new_gap_state", DW'(state_dbg), DW'(ST_GAP));
    step();
    check("t3_new_gap_len1", DW'(state_dbg), DW'(ST_IDLE));
    cfg_pkt_interval = 32'd0;

    // Toggling back-pressure on a 3-beat s1 packet while s0 waits.
    do_reset();
    test_id = 4;
    tready_toggle = 1'b1;
    s_len[1] = 3; s_npkt[1] = 1; s_start[1] = 0;
    s_len[0] = 2; s_npkt[0] = 1; s_start[0] = 1;
    push_pkt(1, 0, 3); push_pkt(0, 0, 2);
    run("t4", 60);
    check("t4_pkt_count0", DW'(pkt_count0_out), DW'(1));
    check("t4_pkt_count1", DW'(pkt_count1_out), DW'(1));
    check("t4_beat_count", DW'(beat_count_out), DW'(5));

    // Reset while beat 2 of a 4-beat s0 packet is on the bus.
    do_reset();
    test_id = 5;
    s_len[0] = 4; s_npkt[0] = 1;
    push_pkt(0, 0, 2);
    step(); step(); step();
    check("t5_beats_seen", DW'(exp_q.size()), DW'(0));
    check("t5_pre_rst_beats", DW'(beat_count_out), DW'(1));
    RST_N = 1'b0;
    #1;
    check("t5_rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    check("t5_rst_s0_tready", DW'(s0_axis_tready), DW'(0));
    check("t5_rst_beat_count", DW'(beat_count_out), DW'(0));
    check("t5_rst_pkt_count0", DW'(pkt_count0_out), DW'(0));
    check("t5_rst_grant", DW'(grant_out), DW'(0));
    check("t5_rst_state", DW'(state_dbg), DW'(ST_IDLE));
    idle_inputs();
    clear_src();
    @(negedge CLK);
    RST_N = 1'b1;
    test_id = 6;
    s_len[0] = 4; s_npkt[0] = 1;
    push_pkt(0, 0, 4);
    run("t5b", 40);
    check("t5_post_pkt_count0", DW'(pkt_count0_out), DW'(1));
    check("t5_post_beat_count", DW'(beat_count_out), DW'(4));

    // Beat counter wrap from 0xFFFFFFFF.
    @(negedge CLK);
    force dut.beat_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.beat_count_q;
    #1;
    check("t6_preset", DW'(beat_count_out), DW'(32'hFFFF_FFFF));
    clear_src();
    test_id = 7;
    s_len[0] = 1; s_npkt[0] = 1;
    push_pkt(0, 0, 1);
    run("t6", 40);
    check("t6_wrap", DW'(beat_count_out), DW'(0));
    check("t6_pkt_count0", DW'(pkt_count0_out), DW'(2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
